// File: rtl/router_depacketizer.sv
// Router egress depacketizer: strips the 3-flit header and emits framed payload words from a FWFT FIFO.
// Optional statistics counters are built when ROUTER_DEPKT_STATS_EN is defined.
module router_depacketizer #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned HDR_DEPTH = 4,
    parameter int unsigned BP_SLACK  = 4,
    parameter int unsigned MAX_LEN   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] d_i,
    input  logic        d_valid_i,
    input  logic        d_sof_i,
    output logic        d_bp_o,
    output logic [63:0] q_o,
    output logic        q_valid_o,
    input  logic        q_ready_i,
    output logic        q_sof_o,
    output logic        q_eof_o,
    output logic        q_err_o,
    output logic [55:0] hdr0_o,
    output logic [55:0] hdr1_o,
    output logic [7:0]  hdr_dst_o,
    output logic [15:0] hdr_len_o,
    output logic        ovf_o,
    output logic [31:0] pkt_cnt_o,
    output logic [31:0] err_cnt_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned HAW = $clog2(HDR_DEPTH);

    typedef logic [AW:0]  pptr_t;
    typedef logic [HAW:0] hptr_t;

    localparam pptr_t DEPTH_P     = pptr_t'(DEPTH);
    localparam pptr_t BP_SLACK_P  = pptr_t'(BP_SLACK);
    localparam hptr_t HDR_DEPTH_P = hptr_t'(HDR_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_LEN,
        S_PAY,
        S_DROP
    } state_e;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic        err;
        logic [63:0] data;
    } pay_t;

    typedef struct packed {
        logic [7:0]  dst;
        logic [55:0] hdr0;
        logic [55:0] hdr1;
        logic [15:0] len;
    } hdr_t;

    // Parser registers
    state_e      state_q, state_d;
    logic [7:0]  dst_q, dst_d;
    logic [55:0] hdr0_q, hdr0_d;
    logic [55:0] hdr1_q, hdr1_d;
    logic [15:0] rem_q, rem_d;
    logic        first_q, first_d;
    logic        ovf_q, ovf_d;
    logic        bp_q, bp_d;

    // FIFO storage and pointers
    pay_t  pay_mem [DEPTH];
    hdr_t  hdr_mem [HDR_DEPTH];
    pptr_t pwr_q, prd_q, pvis_q;
    hptr_t hwr_q, hrd_q;

    pay_t  pay_head, pay_wdata;
    hdr_t  hdr_head, hdr_wdata;
    logic  pay_we, pay_push, pay_pop, pay_full, q_valid;
    logic  hdr_we, hdr_pop, hdr_full, hdr_empty, hdr_vis;
    logic  hdr_ovf, err_inc, pkt_inc;
    pptr_t p_used, p_free;
    hptr_t h_used, h_free;

    // The visible write pointer lags one edge so a word shows one cycle after it is written.
    assign pay_full = (pwr_q[AW] != prd_q[AW]) && (pwr_q[AW-1:0] == prd_q[AW-1:0]);
    assign q_valid  = (pvis_q != prd_q);
    assign pay_head = pay_mem[prd_q[AW-1:0]];
    assign pay_pop  = q_valid & q_ready_i;
    assign pay_push = pay_we & (~pay_full | pay_pop);

    assign hdr_full  = (hwr_q[HAW] != hrd_q[HAW]) && (hwr_q[HAW-1:0] == hrd_q[HAW-1:0]);
    assign hdr_empty = (hwr_q == hrd_q);
    assign hdr_head  = hdr_mem[hrd_q[HAW-1:0]];
    assign hdr_pop   = pay_pop & pay_head.eof & ~hdr_empty;
    assign hdr_wdata = '{dst: dst_q, hdr0: hdr0_q, hdr1: hdr1_q, len: d_i[15:0]};

    assign p_used = pwr_q - prd_q;
    assign p_free = DEPTH_P - p_used;
    assign h_used = hwr_q - hrd_q;
    assign h_free = HDR_DEPTH_P - h_used;
    assign bp_d   = (p_free <= BP_SLACK_P) | (h_free <= hptr_t'(1));
    assign ovf_d  = ovf_q | hdr_ovf | (pay_we & ~pay_push);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        hdr0_d    = hdr0_q;
        hdr1_d    = hdr1_q;
        rem_d     = rem_q;
        first_d   = first_q;
        pay_we    = 1'b0;
        pay_wdata = '0;
        hdr_we    = 1'b0;
        hdr_ovf   = 1'b0;
        err_inc   = 1'b0;
        pkt_inc   = 1'b0;
        if (d_valid_i) begin
            if (d_sof_i) begin
                // A SOF always starts a new packet; anything in progress is aborted.
                err_inc = (state_q != S_IDLE);
                if (state_q == S_PAY) begin
                    pay_we    = 1'b1;
                    pay_wdata = '{sof: 1'b0, eof: 1'b1, err: 1'b1, data: 64'h0};
                end
                dst_d   = d_i[63:56];
                hdr0_d  = d_i[55:0];
                state_d = S_HDR1;
            end else begin
                unique case (state_q)
                    S_IDLE: err_inc = 1'b1;
                    S_HDR1: begin
                        hdr1_d  = d_i[55:0];
                        state_d = S_LEN;
                    end
                    S_LEN: begin
                        rem_d = d_i[15:0];
                        if (d_i[63:16] != '0 || d_i[15:0] == '0) begin
                            err_inc = 1'b1;
                            state_d = S_IDLE;
                        end else if (32'(d_i[15:0]) > MAX_LEN) begin
                            err_inc = 1'b1;
                            state_d = S_DROP;
                        end else if (hdr_full) begin
                            err_inc = 1'b1;
                            hdr_ovf = 1'b1;
                            state_d = S_DROP;
                        end else begin
                            hdr_we  = 1'b1;
                            first_d = 1'b1;
                            state_d = S_PAY;
                        end
                    end
                    S_PAY: begin
                        pay_we    = 1'b1;
                        pay_wdata = '{sof: first_q, eof: (rem_q == 16'd1), err: 1'b0, data: d_i};
                        first_d   = 1'b0;
                        rem_d     = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            pkt_inc = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_DROP: begin
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dst_q   <= '0;
            hdr0_q  <= '0;
            hdr1_q  <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            ovf_q   <= 1'b0;
            bp_q    <= 1'b0;
            pwr_q   <= '0;
            prd_q   <= '0;
            pvis_q  <= '0;
            hwr_q   <= '0;
            hrd_q   <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            hdr0_q  <= hdr0_d;
            hdr1_q  <= hdr1_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            ovf_q   <= ovf_d;
            bp_q    <= bp_d;
            pvis_q  <= pwr_q;
            if (pay_push) pwr_q <= pwr_q + pptr_t'(1);
            if (pay_pop)  prd_q <= prd_q + pptr_t'(1);
            if (hdr_we)   hwr_q <= hwr_q + hptr_t'(1);
            if (hdr_pop)  hrd_q <= hrd_q + hptr_t'(1);
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (pay_push) pay_mem[pwr_q[AW-1:0]] <= pay_wdata;
        if (hdr_we)   hdr_mem[hwr_q[HAW-1:0]] <= hdr_wdata;
    end

    assign hdr_vis   = q_valid & ~hdr_empty;
    assign q_valid_o = q_valid;
    assign q_o       = q_valid ? pay_head.data : 64'h0;
    assign q_sof_o   = q_valid & pay_head.sof;
    assign q_eof_o   = q_valid & pay_head.eof;
    assign q_err_o   = q_valid & pay_head.err;
    assign hdr0_o    = hdr_vis ? hdr_head.hdr0 : 56'h0;
    assign hdr1_o    = hdr_vis ? hdr_head.hdr1 : 56'h0;
    assign hdr_dst_o = hdr_vis ? hdr_head.dst  : 8'h0;
    assign hdr_len_o = hdr_vis ? hdr_head.len  : 16'h0;
    assign d_bp_o    = bp_q;
    assign ovf_o     = ovf_q;

`ifdef ROUTER_DEPKT_STATS_EN
    logic [31:0] pkt_cnt_q, err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (pkt_inc) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (err_inc) err_cnt_q <= err_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = pkt_inc | err_inc;
    assign pkt_cnt_o    = '0;
    assign err_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_router_depacketizer.sv
// Self-checking bench for router_depacketizer: table of packets plus hand sequences, scoreboard on the output.
module tb_router_depacketizer;

    localparam int MAX_LEN = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] d = '0;
    logic        d_valid = 1'b0;
    logic        d_sof = 1'b0;
    logic        d_bp;
    logic [63:0] q;
    logic        q_valid;
    logic        q_ready = 1'b0;
    logic        q_sof, q_eof, q_err;
    logic [55:0] hdr0, hdr1;
    logic [7:0]  hdr_dst;
    logic [15:0] hdr_len;
    logic        ovf;
    logic [31:0] pkt_cnt, err_cnt;

    router_depacketizer #(
        .DEPTH(32), .HDR_DEPTH(4), .BP_SLACK(4), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .d_i(d), .d_valid_i(d_valid), .d_sof_i(d_sof), .d_bp_o(d_bp),
        .q_o(q), .q_valid_o(q_valid), .q_ready_i(q_ready),
        .q_sof_o(q_sof), .q_eof_o(q_eof), .q_err_o(q_err),
        .hdr0_o(hdr0), .hdr1_o(hdr1), .hdr_dst_o(hdr_dst), .hdr_len_o(hdr_len),
        .ovf_o(ovf), .pkt_cnt_o(pkt_cnt), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        sof, eof, err;
        logic [7:0]  dst;
        logic [55:0] h0, h1;
        logic [15:0] len;
    } exp_t;

    typedef struct {
        logic [7:0]  dst;
        logic [55:0] h0, h1;
        logic [63:0] len_flit;
        int          n_pay;
        logic [63:0] base;
        bit          exp_ok;
        int          ready_pct;
    } vec_t;

    exp_t        sb[$];
    exp_t        got;
    vec_t        vecs[9];
    int          total = 0, bad = 0;
    int          exp_pkt = 0, exp_err = 0;
    int          ready_pct = 100;
    int          bp_lag = 0;
    logic [7:0]  bp_hist = '0;
    int          pay_sent = 0;
    bit          bp_seen = 1'b0;
    int          bp_at = -1;
    logic [7:0]  cur_dst;
    logic [55:0] cur_h0, cur_h1;
    logic [15:0] cur_len;

    function automatic int stat(input int v);
`ifdef ROUTER_DEPKT_STATS_EN
        return v;
`else
        return v & 0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string name);
        check({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(stat(exp_pkt)));
        check({name, "_err_cnt"}, 64'(err_cnt), 64'(stat(exp_err)));
    endtask

    // Source model: sends one flit per slot, honouring d_bp with bp_lag slots of delay.
    task automatic send_flit(input logic [63:0] data, input logic sof);
        int guard = 0;
        bp_hist = {bp_hist[6:0], d_bp};
        while (bp_hist[bp_lag] == 1'b1) begin
            d_valid = 1'b0;
            @(posedge clk); #1;
            guard++;
            if (guard > 5000) begin
                $display("FAIL send_flit: source held off by d_bp for %0d cycles", guard);
                bad++;
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "source stalled");
            end
            bp_hist = {bp_hist[6:0], d_bp};
        end
        d = data; d_sof = sof; d_valid = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0; d_sof = 1'b0; d = '0;
    endtask

    task automatic send_hdr(input logic [7:0] dst, input logic [55:0] h0, input logic [55:0] h1,
                            input logic [63:0] len_flit);
        cur_dst = dst; cur_h0 = h0; cur_h1 = h1; cur_len = len_flit[15:0];
        send_flit({dst, h0}, 1'b1);
        send_flit({8'hC3, h1}, 1'b0);
        send_flit(len_flit, 1'b0);
    endtask

    task automatic send_pay(input logic [63:0] base, input int n_send, input int n_total, input bit push);
        for (int i = 0; i < n_send; i++) begin
            logic [63:0] w;
            w = base + 64'(i + 1);
            if (push) sb.push_back('{w, (i == 0), (i == n_total - 1), 1'b0, cur_dst, cur_h0, cur_h1, cur_len});
            send_flit(w, 1'b0);
            pay_sent++;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain_left"}, 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_idle_q_valid"}, 64'(q_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_q"}, q, 64'd0);
        check({name, "_flags"}, 64'({q_valid, q_sof, q_eof, q_err, d_bp, ovf}), 64'd0);
        check({name, "_hdr0"}, 64'(hdr0), 64'd0);
        check({name, "_hdr1_dst_len"}, 64'({hdr1[31:0], hdr_dst, hdr_len}), 64'd0);
        check({name, "_cnts"}, {pkt_cnt, err_cnt}, 64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        q_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // Output monitor: every accepted word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && q_valid && q_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_word: got q=%h sof=%b eof=%b err=%b, expected no word", q, q_sof, q_eof, q_err);
            end else begin
                got = sb.pop_front();
                check("q_data", q, got.data);
                check("q_flags", 64'({q_sof, q_eof, q_err}), 64'({got.sof, got.eof, got.err}));
                check("hdr0", 64'(hdr0), 64'(got.h0));
                check("hdr1", 64'(hdr1), 64'(got.h1));
                check("hdr_dst_len", 64'({hdr_dst, hdr_len}), 64'({got.dst, got.len}));
            end
        end
        if (d_bp && !bp_seen) begin
            bp_seen = 1'b1;
            bp_at   = pay_sent;
        end
    end

    initial begin
        vecs[0] = '{8'h01, 56'h1,      56'h2,      64'd10,               10,   64'h0,                  1'b1, 100};
        vecs[1] = '{8'h7E, 56'hABCDEF, 56'h123456, 64'd1,                1,    64'h7700_0000_0000_0000, 1'b1, 50};
        vecs[2] = '{8'h10, 56'h10,     56'h11,     64'd0,                0,    64'h0,                  1'b0, 100};
        vecs[3] = '{8'h20, 56'h20,     56'h21,     64'd2000,             2000, 64'h2000_0000_0000_0000, 1'b0, 100};
        vecs[4] = '{8'h30, 56'h30,     56'h31,     64'd6,                6,    64'h3000_0000_0000_0000, 1'b1, 100};
        vecs[5] = '{8'h40, 56'h40,     56'h41,     {48'h1, 16'd5},       0,    64'h0,                  1'b0, 100};
        vecs[6] = '{8'h50, 56'h50,     56'h51,     64'(MAX_LEN),         MAX_LEN, 64'h5000_0000_0000_0000, 1'b1, 70};
        vecs[7] = '{8'h60, 56'h60,     56'h61,     64'(MAX_LEN + 1),     MAX_LEN + 1, 64'h0,           1'b0, 100};
        vecs[8] = '{8'h70, 56'h70,     56'h71,     64'd3,                3,    64'h7000_0000_0000_0000, 1'b1, 30};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: first payload word becomes visible one edge after it is accepted.
        ready_pct = 0;
        send_hdr(8'h05, 56'hAA, 56'hBB, 64'd1);
        send_pay(64'h100, 1, 1, 1'b1);
        check("lat_edge_t", 64'(q_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_edge_t1", 64'(q_valid), 64'd1);
        check("lat_hdr_len", 64'(hdr_len), 64'd1);
        exp_pkt++;
        ready_pct = 100;
        wait_drain("lat");
        check_counts("lat");

        for (int k = 0; k < 9; k++) begin
            ready_pct = vecs[k].ready_pct;
            send_hdr(vecs[k].dst, vecs[k].h0, vecs[k].h1, vecs[k].len_flit);
            send_pay(vecs[k].base, vecs[k].n_pay, vecs[k].n_pay, vecs[k].exp_ok);
            if (vecs[k].exp_ok) exp_pkt++;
            else exp_err++;
            wait_drain($sformatf("vec%0d", k));
            check_counts($sformatf("vec%0d", k));
        end

        // Abort in PAY after 3 of 10 words, then a clean packet.
        ready_pct = 100;
        send_hdr(8'h33, 56'hA1, 56'hA2, 64'd10);
        send_pay(64'hA000, 3, 10, 1'b1);
        sb.push_back('{64'h0, 1'b0, 1'b1, 1'b1, cur_dst, cur_h0, cur_h1, cur_len});
        exp_err++;
        send_hdr(8'h44, 56'hB1, 56'hB2, 64'd5);
        send_pay(64'hB000, 5, 5, 1'b1);
        exp_pkt++;
        wait_drain("abort_pay");
        check_counts("abort_pay");

        // Abort in HDR1: a second SOF restarts the header.
        send_flit({8'h55, 56'hC1}, 1'b1);
        send_hdr(8'h66, 56'hC2, 56'hC3, 64'd2);
        send_pay(64'hC000, 2, 2, 1'b1);
        exp_err++;
        exp_pkt++;
        wait_drain("abort_hdr1");
        check_counts("abort_hdr1");

        // Stray flit in IDLE.
        send_flit(64'hDEAD_BEEF, 1'b0);
        exp_err++;
        repeat (2) @(posedge clk);
        #1;
        check_counts("stray");
        check("stray_q_valid", 64'(q_valid), 64'd0);

        // Header FIFO occupancy drives d_bp once only one entry is free.
        ready_pct = 0;
        for (int p = 0; p < 2; p++) begin
            send_hdr(8'h80 + 8'(p), 56'h800 + 56'(p), 56'h900 + 56'(p), 64'd1);
            send_pay(64'hD000 + 64'(p * 16), 1, 1, 1'b1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("bp_hdr_two", 64'(d_bp), 64'd0);
        send_hdr(8'h82, 56'h802, 56'h902, 64'd1);
        send_pay(64'hD100, 1, 1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("bp_hdr_three", 64'(d_bp), 64'd1);
        exp_pkt += 3;
        ready_pct = 100;
        wait_drain("bp_hdr");
        check("bp_hdr_clear", 64'(d_bp), 64'd0);
        check_counts("bp_hdr");

        // Payload backpressure: 40-word packet, consumer stalled, source reacts 3 slots late.
        ready_pct = 0;
        bp_lag    = 3;
        bp_hist   = '0;
        bp_seen   = 1'b0;
        pay_sent  = 0;
        fork
            begin
                send_hdr(8'h99, 56'hE1, 56'hE2, 64'd40);
                send_pay(64'hE000, 40, 40, 1'b1);
            end
            begin
                repeat (80) @(posedge clk);
                #1;
                ready_pct = 100;
            end
        join
        exp_pkt++;
        wait_drain("bp_pay");
        bp_lag = 0;
        // Registered: rises one edge after the 28th entry is written.
        check("bp_rise_at", 64'(bp_at), 64'd29);
        check("bp_ovf", 64'(ovf), 64'd0);
        check_counts("bp_pay");

        // Reset in the middle of a payload.
        ready_pct = 0;
        send_hdr(8'hAB, 56'hF1, 56'hF2, 64'd10);
        send_pay(64'hF000, 4, 10, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_q_valid", 64'(q_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_q_valid", 64'(q_valid), 64'd0);
        exp_pkt = 0;
        exp_err = 0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        ready_pct = 100;
        send_hdr(8'hCD, 56'h71, 56'h72, 64'd4);
        send_pay(64'h7100, 4, 4, 1'b1);
        exp_pkt++;
        wait_drain("post_rst");
        check_counts("post_rst");
        check("final_ovf", 64'(ovf), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
